// File: rtl/if_stage.sv
`timescale 1ns/1ps
// if_stage: instruction-fetch stage plus IF/ID pipeline register.
// Owns the fetch PC, drives the instruction-memory request, parks a word
// fetched during an ID stall in a one-entry hold buffer, and applies
// ID-computed redirects (one delay slot) and exception flushes.
//
// Memory handshake: imem_req=1 means imem_addr is a live request and both
// stay stable until the cycle in which imem_valid=1; that cycle completes the
// fetch (same-cycle response allowed). imem_valid is ignored while
// imem_req=0. A flush abandons the live request without waiting.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] FLUSH_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   output logic [31:0] instr_D,
   output logic [31:0] pc_D,
   output logic [31:0] pc8_D,
   output logic        valid_D,
   output logic        state_dbg
);

   typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

   state_t      state, state_nx;
   logic [31:0] pc_f, pc_f_nx;
   logic        pend_v, pend_v_nx;
   logic [31:0] pend_pc, pend_pc_nx;
   logic [31:0] buf_instr, buf_instr_nx;
   logic [31:0] buf_pc, buf_pc_nx;
   logic [31:0] instr_d_nx, pc_d_nx;
   logic        valid_d_nx;
   logic        capture, release_hold;

   // a fetch completes only in FETCH; HOLD releases when ID accepts
   assign capture      = (state == S_FETCH) && imem_valid;
   assign release_hold = (state == S_HOLD) && !stall;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_nx;
   end

   // FSM next state: park a word under stall, resume when ID frees up
   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH: if (imem_valid && stall) state_nx = S_HOLD;
         S_HOLD:  if (!stall)              state_nx = S_FETCH;
         default: state_nx = S_FETCH;
      endcase
      if (flush) state_nx = S_FETCH;
   end

   // FSM outputs: request only in FETCH and never while reset is held
   always_comb begin
      imem_req  = reset_n && (state == S_FETCH);
      imem_addr = pc_f;
      state_dbg = (state == S_HOLD);
   end

   // next fetch PC and pending-redirect bookkeeping
   always_comb begin
      pc_f_nx    = pc_f;
      pend_v_nx  = pend_v;
      pend_pc_nx = pend_pc;
      if (capture || release_hold) begin
         // the delay slot is done (or already parked): the target goes next
         if (redirect) begin
            pc_f_nx   = redirect_pc;
            pend_v_nx = 1'b0;
         end else if (pend_v) begin
            pc_f_nx   = pend_pc;
            pend_v_nx = 1'b0;
         end else if (capture) begin
            pc_f_nx = pc_f + 32'd4;
         end
      end else if (redirect) begin
         // latest redirect wins until the delay slot has been fetched
         pend_v_nx  = 1'b1;
         pend_pc_nx = redirect_pc;
      end
      if (flush) begin
         pc_f_nx    = FLUSH_PC;
         pend_v_nx  = 1'b0;
         pend_pc_nx = 32'd0;
      end
   end

   // next IF/ID register and hold-buffer contents
   always_comb begin
      instr_d_nx   = instr_D;
      pc_d_nx      = pc_D;
      valid_d_nx   = valid_D;
      buf_instr_nx = buf_instr;
      buf_pc_nx    = buf_pc;
      if (flush) begin
         instr_d_nx   = 32'd0;
         pc_d_nx      = 32'd0;
         valid_d_nx   = 1'b0;
         buf_instr_nx = 32'd0;
         buf_pc_nx    = 32'd0;
      end else if (state == S_FETCH) begin
         if (imem_valid && !stall) begin
            instr_d_nx = imem_rdata;
            pc_d_nx    = pc_f;
            valid_d_nx = 1'b1;
         end else if (imem_valid) begin
            buf_instr_nx = imem_rdata;
            buf_pc_nx    = pc_f;
         end else if (!stall) begin
            instr_d_nx = 32'd0;
            pc_d_nx    = 32'd0;
            valid_d_nx = 1'b0;
         end
      end else if (release_hold) begin
         instr_d_nx = buf_instr;
         pc_d_nx    = buf_pc;
         valid_d_nx = 1'b1;
      end
   end

   // datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_f      <= RESET_PC;
         pend_v    <= 1'b0;
         pend_pc   <= 32'd0;
         buf_instr <= 32'd0;
         buf_pc    <= 32'd0;
         instr_D   <= 32'd0;
         pc_D      <= 32'd0;
         valid_D   <= 1'b0;
      end else begin
         pc_f      <= pc_f_nx;
         pend_v    <= pend_v_nx;
         pend_pc   <= pend_pc_nx;
         buf_instr <= buf_instr_nx;
         buf_pc    <= buf_pc_nx;
         instr_D   <= instr_d_nx;
         pc_D      <= pc_d_nx;
         valid_D   <= valid_d_nx;
      end
   end

   // link address for jal/bgezal-style instructions in ID
   assign pc8_D = pc_D + 32'd8;

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Bench for if_stage: directed table of per-cycle vectors, a reset-mid-fetch
// sequence, and a randomized run against a transaction-level fetch model.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] FLUSH_PC = 32'h0000_4180;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [31:0] instr_D, pc_D, pc8_D;
   logic        valid_D;
   logic        state_dbg;

   if_stage #(.RESET_PC(RESET_PC), .FLUSH_PC(FLUSH_PC)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush),
      .instr_D(instr_D), .pc_D(pc_D), .pc8_D(pc8_D), .valid_D(valid_D),
      .state_dbg(state_dbg)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic s, input logic v, input logic [31:0] rd,
                        input logic r, input logic [31:0] rpc, input logic f);
      stall = s; imem_valid = v; imem_rdata = rd;
      redirect = r; redirect_pc = rpc; flush = f;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req",   {31'd0, imem_req}, 32'd0);
      chk("rst_vd",    {31'd0, valid_D},  32'd0);
      chk("rst_pcd",   pc_D,              32'd0);
      chk("rst_instr", instr_D,           32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst_rel_req",  {31'd0, imem_req}, 32'd1);
      chk("rst_rel_addr", imem_addr,         RESET_PC);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        s, v;
      logic [31:0] rd;
      logic        r;
      logic [31:0] rpc;
      logic        f;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vd;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic v, logic [31:0] rd, logic r, logic [31:0] rpc,
                               logic f, logic e_req, logic [31:0] e_addr, logic e_vd,
                               logic [31:0] e_pc, logic [31:0] e_instr);
      vec_t x;
      x.s = s; x.v = v; x.rd = rd; x.r = r; x.rpc = rpc; x.f = f;
      x.e_req = e_req; x.e_addr = e_addr; x.e_vd = e_vd; x.e_pc = e_pc; x.e_instr = e_instr;
      return x;
   endfunction

   // ---------------- scoreboard / reference model ----------------
   // exp_q holds completed fetches not yet handed to ID: {instr, pc}
   logic [63:0] exp_q[$];
   logic [31:0] m_addr;      // address of the live (or next) request
   logic [31:0] m_base;      // fall-through after the last completed fetch
   logic        m_pend;
   logic [31:0] m_pend_pc;
   logic        e_vd;
   logic [31:0] e_pc, e_instr;

   task automatic model_reset();
      exp_q.delete();
      m_addr = RESET_PC; m_base = RESET_PC; m_pend = 1'b0; m_pend_pc = 32'd0;
      e_vd = 1'b0; e_pc = 32'd0; e_instr = 32'd0;
   endtask

   // Predict the effect of the upcoming clock edge from the applied inputs.
   task automatic model_step();
      logic        req;
      logic [63:0] w;
      req = (exp_q.size() == 0);
      if (flush) begin
         exp_q.delete();
         m_pend = 1'b0;
         m_addr = FLUSH_PC;
         e_vd = 1'b0; e_pc = 32'd0; e_instr = 32'd0;
      end else begin
         if (redirect) begin
            m_pend = 1'b1; m_pend_pc = redirect_pc;
         end
         if (req && imem_valid) begin
            exp_q.push_back({imem_rdata, m_addr});
            m_base = m_addr + 32'd4;
         end
         if (!stall) begin
            if (exp_q.size() > 0) begin
               w = exp_q.pop_front();
               e_instr = w[63:32]; e_pc = w[31:0]; e_vd = 1'b1;
               m_addr = m_pend ? m_pend_pc : m_base;
               m_pend = 1'b0;
            end else begin
               e_vd = 1'b0; e_pc = 32'd0; e_instr = 32'd0;
            end
         end
      end
   endtask

   task automatic model_check();
      logic req;
      req = (exp_q.size() == 0);
      chk("rnd_req", {31'd0, imem_req}, {31'd0, req});
      if (req) chk("rnd_addr", imem_addr, m_addr);
      chk("rnd_vd", {31'd0, valid_D}, {31'd0, e_vd});
      if (e_vd) begin
         chk("rnd_pcd",   pc_D,    e_pc);
         chk("rnd_instr", instr_D, e_instr);
         chk("rnd_pc8",   pc8_D,   e_pc + 32'd8);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      drive(0, 0, 0, 0, 0, 0);
      do_reset();

      //            s v rdata          r rpc            f  req addr           vd pc             instr
      vecs.push_back(mk(0,1,32'h3000,      0,32'h0,       0, 1,32'h3004,      1,32'h3000,     32'h3000));
      vecs.push_back(mk(0,1,32'h3004,      0,32'h0,       0, 1,32'h3008,      1,32'h3004,     32'h3004));
      vecs.push_back(mk(0,1,32'h3008,      0,32'h0,       0, 1,32'h300C,      1,32'h3008,     32'h3008));
      vecs.push_back(mk(0,0,32'h0,         0,32'h0,       0, 1,32'h300C,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,0,32'h0,         0,32'h0,       0, 1,32'h300C,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,1,32'h300C,      0,32'h0,       0, 1,32'h3010,      1,32'h300C,     32'h300C));
      vecs.push_back(mk(1,1,32'h3010,      0,32'h0,       0, 0,32'h0,         1,32'h300C,     32'h300C));
      vecs.push_back(mk(1,0,32'h0,         0,32'h0,       0, 0,32'h0,         1,32'h300C,     32'h300C));
      vecs.push_back(mk(1,1,32'hDEADBEEF,  0,32'h0,       0, 0,32'h0,         1,32'h300C,     32'h300C));
      vecs.push_back(mk(1,0,32'h0,         0,32'h0,       0, 0,32'h0,         1,32'h300C,     32'h300C));
      vecs.push_back(mk(0,0,32'h0,         0,32'h0,       0, 1,32'h3014,      1,32'h3010,     32'h3010));
      vecs.push_back(mk(0,1,32'h3014,      0,32'h0,       0, 1,32'h3018,      1,32'h3014,     32'h3014));
      vecs.push_back(mk(0,0,32'h0,         1,32'h3100,    0, 1,32'h3018,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,1,32'h3018,      0,32'h0,       0, 1,32'h3100,      1,32'h3018,     32'h3018));
      vecs.push_back(mk(0,1,32'h3100,      0,32'h0,       0, 1,32'h3104,      1,32'h3100,     32'h3100));
      vecs.push_back(mk(0,1,32'h3104,      1,32'h3200,    0, 1,32'h3200,      1,32'h3104,     32'h3104));
      vecs.push_back(mk(1,1,32'h3200,      0,32'h0,       0, 0,32'h0,         1,32'h3104,     32'h3104));
      vecs.push_back(mk(1,0,32'h0,         1,32'h3300,    0, 0,32'h0,         1,32'h3104,     32'h3104));
      vecs.push_back(mk(0,0,32'h0,         0,32'h0,       0, 1,32'h3300,      1,32'h3200,     32'h3200));
      vecs.push_back(mk(1,1,32'h3300,      1,32'h3400,    1, 1,32'h4180,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,1,32'h4180,      0,32'h0,       0, 1,32'h4184,      1,32'h4180,     32'h4180));
      vecs.push_back(mk(0,1,32'h4184,      1,32'hFFFFFFFC,0, 1,32'hFFFFFFFC,  1,32'h4184,     32'h4184));
      vecs.push_back(mk(0,1,32'hFFFFFFFC,  0,32'h0,       0, 1,32'h0,         1,32'hFFFFFFFC, 32'hFFFFFFFC));
      vecs.push_back(mk(0,1,32'h0,         0,32'h0,       0, 1,32'h4,         1,32'h0,        32'h0));
      vecs.push_back(mk(1,1,32'h4,         0,32'h0,       0, 0,32'h0,         1,32'h0,        32'h0));
      vecs.push_back(mk(1,0,32'h0,         0,32'h0,       1, 1,32'h4180,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,0,32'h0,         0,32'h0,       0, 1,32'h4180,      0,32'h0,        32'h0));
      vecs.push_back(mk(0,1,32'h4180,      0,32'h0,       0, 1,32'h4184,      1,32'h4180,     32'h4180));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].s, vecs[i].v, vecs[i].rd, vecs[i].r, vecs[i].rpc, vecs[i].f);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         if (vecs[i].e_req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
         chk($sformatf("vec%0d_vd", i), {31'd0, valid_D}, {31'd0, vecs[i].e_vd});
         if (vecs[i].e_vd) begin
            chk($sformatf("vec%0d_pcd", i),   pc_D,    vecs[i].e_pc);
            chk($sformatf("vec%0d_instr", i), instr_D, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc8", i),   pc8_D,   vecs[i].e_pc + 32'd8);
         end
      end

      // reset asserted in the middle of a fetch: request dropped at once
      @(negedge clk);
      drive(0, 1, 32'h1234_5678, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      chk("midrst_vd",  {31'd0, valid_D},  32'd0);
      chk("midrst_pcd", pc_D,              32'd0);

      // randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         drive($urandom_range(0, 3) == 0,
               $urandom_range(0, 2) != 0,
               $urandom,
               $urandom_range(0, 7) == 0,
               ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom,
               $urandom_range(0, 40) == 0);
         model_step();
         @(posedge clk);
         #1;
         model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
